// File: rtl/mdu_pkg.sv
// Shared constants for the execute-stage multiply/divide unit.
// The decoder uses the op codes too.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage request/response bundle between the pipeline and the MDU.
interface e_mdu_if;
  import mdu_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] op;
  logic [31:0]         V1_E;
  logic [31:0]         V2_E;
  logic                EXC_flush;
  logic                busy;
  logic                stall_req;
  logic [31:0]         HI;
  logic [31:0]         LO;

  modport master (
    output start, op, V1_E, V2_E, EXC_flush,
    input  busy, stall_req, HI, LO
  );

  modport slave (
    input  start, op, V1_E, V2_E, EXC_flush,
    output busy, stall_req, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; a divide by zero returns hi_in/lo_in
// unchanged so the op retires without disturbing HI/LO.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [31:0]         hi_in,
  input  logic [31:0]         lo_in,
  output logic [31:0]         res_hi,
  output logic [31:0]         res_lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, sq, sr;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
    a_mag  = (op == MD_DIV && a[31]) ? -a : a;
    b_mag  = (op == MD_DIV && b[31]) ? -b : b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    sq     = (a[31] ^ b[31]) ? -uq : uq;
    sr     = a[31] ? -ur : ur;

    res_hi = hi_in;
    res_lo = lo_in;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency md ops, single-cycle
// mthi/mtlo, architectural HI/LO and the stall request for the hazard unit.
//   state  | meaning
//   S_IDLE | cnt=0, accepts a new op, mthi/mtlo write directly
//   S_RUN  | result held in pend_*, cnt counts down to commit
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   mdu
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 4) ? 4 : $clog2(CNT_MAX + 1);

  mdu_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      hi_q, lo_q, hi_nx, lo_nx;
  logic [31:0]      pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
  logic [31:0]      res_hi, res_lo;
  logic             accept;

  mdu_arith u_arith (
    .op     (mdu.op),
    .a      (mdu.V1_E),
    .b      (mdu.V2_E),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    accept     = mdu.start && !mdu.EXC_flush;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (mdu.op)
            MD_MULT, MD_MULTU: begin
              pend_hi_nx = res_hi;
              pend_lo_nx = res_lo;
              cnt_nx     = CNT_W'(MULT_CYCLES);
              state_nx   = S_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_nx = res_hi;
              pend_lo_nx = res_lo;
              cnt_nx     = CNT_W'(DIV_CYCLES);
              state_nx   = S_RUN;
            end
            MD_MTHI: hi_nx = mdu.V1_E;
            MD_MTLO: lo_nx = mdu.V1_E;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Flush outranks the final commit edge: a cancelled op never retires.
        if (mdu.EXC_flush) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          cnt_nx   = '0;
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mdu.busy      = (state == S_RUN);
  assign mdu.stall_req = (state == S_RUN) ||
                         (mdu.start && (mdu.op <= MD_DIVU) && !mdu.EXC_flush);
  assign mdu.HI        = hi_q;
  assign mdu.LO        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, results, flush, reset and back-to-back.
module tb_e_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   nb, ns, nb2, ns2;

  e_mdu_if mif ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one md op; returns busy-cycle and stall-cycle counts (stall incl. start cycle).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n_busy, output int n_stall);
    mif.start = 1'b1; mif.op = o; mif.V1_E = a; mif.V2_E = b;
    #1;
    n_stall = int'(mif.stall_req);
    tick();
    mif.start = 1'b0;
    n_busy = 0;
    while (mif.busy && n_busy < 40) begin
      n_busy++;
      n_stall += int'(mif.stall_req);
      tick();
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    mif.start = 1'b1; mif.op = o; mif.V1_E = v; mif.V2_E = 32'h0;
    #1;
    chk("mt_stall", 32'(mif.stall_req), 32'd0);
    tick();
    mif.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mif.start = 1'b0; mif.op = 3'd0; mif.V1_E = '0; mif.V2_E = '0; mif.EXC_flush = 1'b0;
    #12;
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_hi", mif.HI, 32'd0);
    chk("rst_lo", mif.LO, 32'd0);
    chk("rst_stall", 32'(mif.stall_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // mthi then mtlo on consecutive cycles
    mt(MD_MTHI, 32'hDEADBEEF);
    chk("mthi_hi", mif.HI, 32'hDEADBEEF);
    chk("mthi_busy", 32'(mif.busy), 32'd0);
    mt(MD_MTLO, 32'h12345678);
    chk("mtlo_lo", mif.LO, 32'h12345678);
    chk("mtlo_hi", mif.HI, 32'hDEADBEEF);
    chk("mtlo_busy", 32'(mif.busy), 32'd0);

    // reset mid-op: MULT 3x4, reset during busy cycle 2
    mif.start = 1'b1; mif.op = MD_MULT; mif.V1_E = 32'd3; mif.V2_E = 32'd4;
    tick();
    mif.start = 1'b0;
    tick();
    chk("rmid_busy_pre", 32'(mif.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rmid_busy", 32'(mif.busy), 32'd0);
    chk("rmid_hi", mif.HI, 32'd0);
    chk("rmid_lo", mif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) tick();
    chk("rmid_nocommit_lo", mif.LO, 32'd0);
    chk("rmid_nocommit_busy", 32'(mif.busy), 32'd0);

    // flush at busy cycle 4 of DIV 100/3
    mif.start = 1'b1; mif.op = MD_DIV; mif.V1_E = 32'd100; mif.V2_E = 32'd3;
    tick();
    mif.start = 1'b0;
    repeat (3) tick();
    mif.EXC_flush = 1'b1;
    tick();
    mif.EXC_flush = 1'b0;
    chk("fl4_busy", 32'(mif.busy), 32'd0);
    repeat (10) tick();
    chk("fl4_hi", mif.HI, 32'd0);
    chk("fl4_lo", mif.LO, 32'd0);

    // flush on the cnt=1 edge: nothing committed
    mt(MD_MTLO, 32'h66);
    mif.start = 1'b1; mif.op = MD_DIV; mif.V1_E = 32'd100; mif.V2_E = 32'd3;
    tick();
    mif.start = 1'b0;
    repeat (9) tick();
    chk("fl1_busy_pre", 32'(mif.busy), 32'd1);
    mif.EXC_flush = 1'b1;
    tick();
    mif.EXC_flush = 1'b0;
    chk("fl1_busy", 32'(mif.busy), 32'd0);
    chk("fl1_hi", mif.HI, 32'd0);
    chk("fl1_lo", mif.LO, 32'h66);

    // start with flush in IDLE, and op 6: no effect
    mif.start = 1'b1; mif.op = MD_MULT; mif.EXC_flush = 1'b1; mif.V1_E = 32'd9; mif.V2_E = 32'd9;
    #1;
    chk("idlefl_stall", 32'(mif.stall_req), 32'd0);
    tick();
    mif.EXC_flush = 1'b0; mif.op = 3'd6;
    chk("idlefl_busy", 32'(mif.busy), 32'd0);
    tick();
    mif.start = 1'b0;
    chk("op6_busy", 32'(mif.busy), 32'd0);
    chk("op6_lo", mif.LO, 32'h66);

    // MULT / MULTU
    run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, nb, ns);
    chk("mult_cyc", 32'(nb), 32'd5);
    chk("mult_hi", mif.HI, 32'hFFFFFFFF);
    chk("mult_lo", mif.LO, 32'hFFFFFFFE);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, nb, ns);
    chk("multu_cyc", 32'(nb), 32'd5);
    chk("multu_hi", mif.HI, 32'h00000001);
    chk("multu_lo", mif.LO, 32'hFFFFFFFE);

    // DIV / DIVU / divide-by-zero / overflow
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, nb, ns);
    chk("div_cyc", 32'(nb), 32'd10);
    chk("div_lo", mif.LO, 32'hFFFFFFFD);
    chk("div_hi", mif.HI, 32'hFFFFFFFF);
    run_op(MD_DIVU, 32'hFFFFFFF9, 32'd2, nb, ns);
    chk("divu_lo", mif.LO, 32'h7FFFFFFC);
    chk("divu_hi", mif.HI, 32'h00000001);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run_op(MD_DIVU, 32'd7, 32'd0, nb, ns);
    chk("div0_cyc", 32'(nb), 32'd10);
    chk("div0_hi", mif.HI, 32'h11);
    chk("div0_lo", mif.LO, 32'h22);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, nb, ns);
    chk("ovf_lo", mif.LO, 32'h80000000);
    chk("ovf_hi", mif.HI, 32'h0);

    // MTHI while busy is ignored
    mif.start = 1'b1; mif.op = MD_MULT; mif.V1_E = 32'd2; mif.V2_E = 32'd3;
    tick();
    mif.op = MD_MTHI; mif.V1_E = 32'hBAD0BAD0;
    tick();
    mif.start = 1'b0;
    repeat (5) tick();
    chk("mtbusy_busy", 32'(mif.busy), 32'd0);
    chk("mtbusy_hi", mif.HI, 32'h0);
    chk("mtbusy_lo", mif.LO, 32'd6);

    // back-to-back MULT 5x6 then DIV 30/4
    run_op(MD_MULT, 32'd5, 32'd6, nb, ns);
    chk("b2b_mult_lo", mif.LO, 32'd30);
    run_op(MD_DIV, 32'd30, 32'd4, nb2, ns2);
    chk("b2b_div_cyc", 32'(nb2), 32'd10);
    chk("b2b_div_lo", mif.LO, 32'd7);
    chk("b2b_div_hi", mif.HI, 32'd2);
    chk("b2b_stall", 32'(ns + ns2), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
